// File: rtl/dma_burst_engine.sv
// Single-channel AXI DMA master: splits a word copy into INCR bursts of at most
// MAX_BURST beats that never cross a 4 KB page, staging read data in a small FWFT FIFO.
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | size the next burst from remaining words and page room
// AR     | read address presented
// AW     | write address presented
// XFER   | read beats into FIFO, write beats out of FIFO
// RESP   | waiting for write response, then advance pointers
// DONE   | one-cycle completion pulse
module dma_burst_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [3:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic [3:0]          ARID,
    input  logic                RVALID,
    output logic                RREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [3:0]          AWID,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP
);
    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_AR, S_AW, S_XFER, S_RESP, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] cur_src, cur_dst, step;
    logic [LEN_W-1:0]  remaining;
    logic [4:0]        beats, beats_calc, rd_cnt, wr_cnt;
    logic [12:0]       src_room, dst_room;
    logic              ar_hs, aw_hs, r_hs, w_hs, b_hs, last_w;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic              unused_rlast;

    assign unused_rlast = RLAST;

    assign ARSIZE  = 3'(SIZE);
    assign AWSIZE  = 3'(SIZE);
    assign ARBURST = 2'b01;
    assign AWBURST = 2'b01;
    assign ARID    = 4'd0;
    assign AWID    = 4'd0;
    assign WSTRB   = '1;
    assign ARADDR  = cur_src;
    assign AWADDR  = cur_dst;
    assign ARLEN   = 4'(beats - 5'd1);
    assign AWLEN   = 4'(beats - 5'd1);
    assign WDATA   = fifo_mem[rd_ptr];

    assign ar_hs  = ARVALID && ARREADY;
    assign aw_hs  = AWVALID && AWREADY;
    assign r_hs   = RVALID && RREADY;
    assign w_hs   = WVALID && WREADY;
    assign b_hs   = BVALID && BREADY;
    assign last_w = (wr_cnt == beats - 5'd1);
    assign step   = ADDR_W'(beats) << SIZE;

    assign fifo_full  = (fifo_cnt == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);

    // Words left before each side hits the next 4 KB page.
    assign src_room = (13'd4096 - {1'b0, cur_src[11:0]}) >> SIZE;
    assign dst_room = (13'd4096 - {1'b0, cur_dst[11:0]}) >> SIZE;

    always_comb begin
        beats_calc = 5'(MAX_BURST);
        if (remaining < LEN_W'(MAX_BURST))
            beats_calc = 5'(remaining);
        if (src_room < 13'(beats_calc))
            beats_calc = 5'(src_room);
        if (dst_room < 13'(beats_calc))
            beats_calc = 5'(dst_room);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (length == '0) ? S_DONE : S_CALC;
            S_CALC: state_nxt = S_AR;
            S_AR:   if (ar_hs) state_nxt = S_AW;
            S_AW:   if (aw_hs) state_nxt = S_XFER;
            S_XFER: if (w_hs && last_w) state_nxt = S_RESP;
            S_RESP: if (b_hs)
                        state_nxt = (remaining == LEN_W'(beats) || err || BRESP != 2'b00)
                                    ? S_DONE : S_CALC;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        ARVALID = 1'b0;
        AWVALID = 1'b0;
        RREADY  = 1'b0;
        WVALID  = 1'b0;
        WLAST   = 1'b0;
        BREADY  = 1'b0;
        case (state)
            S_CALC: busy = 1'b1;
            S_AR: begin
                busy    = 1'b1;
                ARVALID = 1'b1;
            end
            S_AW: begin
                busy    = 1'b1;
                AWVALID = 1'b1;
            end
            S_XFER: begin
                busy   = 1'b1;
                RREADY = !fifo_full && (rd_cnt != beats);
                WVALID = !fifo_empty;
                WLAST  = last_w;
            end
            S_RESP: begin
                busy   = 1'b1;
                BREADY = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            beats     <= 5'd1;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            err       <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                cur_src   <= src_addr;
                cur_dst   <= dst_addr;
                remaining <= length;
                err       <= 1'b0;
            end else if ((r_hs && RRESP != 2'b00) || (b_hs && BRESP != 2'b00)) begin
                err <= 1'b1;
            end
            if (state == S_CALC) begin
                beats  <= beats_calc;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end
            if (r_hs)
                rd_cnt <= rd_cnt + 5'd1;
            if (w_hs)
                wr_cnt <= wr_cnt + 5'd1;
            if (b_hs) begin
                cur_src   <= cur_src + step;
                cur_dst   <= cur_dst + step;
                remaining <= remaining - LEN_W'(beats);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_hs)
            fifo_mem[wr_ptr] <= RDATA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (r_hs)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (w_hs)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({r_hs, w_hs})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine: background AXI slave with a synthetic memory,
// hand-computed burst addresses/lengths and copied data checked with immediate assertions.
module tb_dma_burst_engine;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr, length;
    logic        busy, done, err;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN, ARID;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        RVALID, RREADY, RLAST;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN, AWID;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        WVALID, WREADY, WLAST;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0, arv_cyc = 0, awv_cyc = 0, rstall = 0, b_pend = 0, w_hold = 0;
    bit r_gaps = 0, r_took = 0, b_took = 0, b_err_next = 0, r_err_en = 0;
    logic [31:0] r_err_addr = 32'h0;
    logic [31:0] ar_addr_log[$], aw_addr_log[$], wd_log[$], rq_addr[$];
    logic [3:0]  ar_len_log[$], aw_len_log[$];
    bit          wl_log[$], rq_last[$];

    dma_burst_engine #(
        .DATA_W(32), .ADDR_W(32), .LEN_W(32), .MAX_BURST(16), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .length(length), .busy(busy), .done(done), .err(err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave bookkeeping on the active edge (pre-update values).
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (ARVALID) arv_cyc++;
        if (AWVALID) awv_cyc++;
        if (RVALID && !RREADY && WVALID) rstall++;
        if (RVALID && RREADY) begin
            void'(rq_addr.pop_front());
            void'(rq_last.pop_front());
            r_took = 1;
        end
        if (ARVALID && ARREADY) begin
            ar_addr_log.push_back(ARADDR);
            ar_len_log.push_back(ARLEN);
            for (int i = 0; i <= int'(ARLEN); i++) begin
                rq_addr.push_back(ARADDR + 32'(4 * i));
                rq_last.push_back(i == int'(ARLEN));
            end
        end
        if (AWVALID && AWREADY) begin
            aw_addr_log.push_back(AWADDR);
            aw_len_log.push_back(AWLEN);
        end
        if (WVALID && WREADY) begin
            wd_log.push_back(WDATA);
            wl_log.push_back(WLAST);
            if (WLAST) b_pend++;
        end
        if (BVALID && BREADY) begin
            b_pend--;
            b_took = 1;
            if (BRESP != 2'b00) b_err_next = 0;
        end
    end

    // Slave drivers, updated on the falling edge.
    initial begin
        ARREADY = 1; AWREADY = 1; WREADY = 1;
        RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
        BVALID = 0; BRESP = 0;
        forever begin
            @(negedge clk);
            if (!(RVALID && !r_took)) begin
                if (rq_addr.size() > 0 && (!r_gaps || $urandom_range(0, 2) != 0)) begin
                    RVALID = 1;
                    RDATA  = fdata(rq_addr[0]);
                    RLAST  = rq_last[0];
                    RRESP  = (r_err_en && rq_addr[0] == r_err_addr) ? 2'b10 : 2'b00;
                end else begin
                    RVALID = 0; RLAST = 0; RRESP = 0;
                end
            end
            r_took = 0;
            WREADY = (w_hold == 0);
            if (w_hold > 0) w_hold--;
            if (!(BVALID && !b_took)) begin
                BVALID = (b_pend > 0);
                BRESP  = (b_pend > 0 && b_err_next) ? 2'b10 : 2'b00;
            end
            b_took = 0;
        end
    end

    task automatic clear_logs();
        ar_addr_log.delete(); ar_len_log.delete();
        aw_addr_log.delete(); aw_len_log.delete();
        wd_log.delete(); wl_log.delete();
        rstall = 0;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        @(negedge clk);
        clear_logs();
        src_addr = s; dst_addr = d; length = l; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, done_cnt != d0, 1);
    endtask

    task automatic check_copy(input string tag, input logic [31:0] s, input int l);
        chk({tag, "_nwords"}, wd_log.size(), l);
        for (int i = 0; i < l; i++)
            chk({tag, "_wdata"}, (i < wd_log.size()) ? wd_log[i] : 32'hx, fdata(s + 32'(4 * i)));
    endtask

    initial begin
        int k, d0, a0, w0;
        rst = 0; start = 0; src_addr = 0; dst_addr = 0; length = 0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, err, ARVALID, AWVALID, RREADY, WVALID, WLAST, BREADY}, 9'b0);
        chk("const_outs", {ARSIZE, ARBURST, ARID, AWSIZE, AWBURST, AWID, WSTRB},
            {3'd2, 2'b01, 4'd0, 3'd2, 2'b01, 4'd0, 4'hF});
        rst = 1;
        @(negedge clk);

        // Basic 3-word copy with timing of the first cycles
        d0 = done_cnt;
        do_start(32'h1000, 32'h2000, 3);
        chk("basic_busy_n1", {busy, ARVALID}, 2'b10);
        @(negedge clk);
        chk("basic_ar_n2", {ARVALID, ARADDR, ARLEN}, {1'b1, 32'h1000, 4'd2});
        wait_done("basic", 100);
        chk("basic_busy_after", busy, 0);
        repeat (3) @(negedge clk);
        chk("basic_done_pulses", done_cnt - d0, 1);
        chk("basic_aw", {32'(aw_addr_log.size()), aw_addr_log[0], aw_len_log[0]}, {32'd1, 32'h2000, 4'd2});
        check_copy("basic", 32'h1000, 3);
        chk("basic_wlast", {wl_log[0], wl_log[1], wl_log[2]}, 3'b001);
        chk("basic_err", err, 0);

        // 40 words split 16/16/8
        do_start(32'h1000, 32'h2000, 40);
        wait_done("split", 300);
        chk("split_nar", ar_addr_log.size(), 3);
        chk("split_ar", {ar_addr_log[0], ar_addr_log[1], ar_addr_log[2]}, {32'h1000, 32'h1040, 32'h1080});
        chk("split_arlen", {ar_len_log[0], ar_len_log[1], ar_len_log[2]}, {4'd15, 4'd15, 4'd7});
        chk("split_aw", {aw_addr_log[0], aw_addr_log[1], aw_addr_log[2]}, {32'h2000, 32'h2040, 32'h2080});
        chk("split_awlen", {aw_len_log[0], aw_len_log[1], aw_len_log[2]}, {4'd15, 4'd15, 4'd7});
        check_copy("split", 32'h1000, 40);

        // 4 KB crossing on the source side
        do_start(32'h0FF8, 32'h3000, 8);
        wait_done("pg_src", 200);
        chk("pg_src_ar", {ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]},
            {32'h0FF8, 4'd1, 32'h1000, 4'd5});
        chk("pg_src_aw", {aw_addr_log[0], aw_len_log[0], aw_addr_log[1], aw_len_log[1]},
            {32'h3000, 4'd1, 32'h3008, 4'd5});
        check_copy("pg_src", 32'h0FF8, 8);

        // 4 KB crossing on the destination side
        do_start(32'h2000, 32'h5FF0, 6);
        wait_done("pg_dst", 200);
        chk("pg_dst_ar", {ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]},
            {32'h2000, 4'd3, 32'h2010, 4'd1});
        chk("pg_dst_aw", {aw_addr_log[0], aw_len_log[0], aw_addr_log[1], aw_len_log[1]},
            {32'h5FF0, 4'd3, 32'h6000, 4'd1});
        check_copy("pg_dst", 32'h2000, 6);

        // Zero length: done next cycle, no AXI traffic
        a0 = arv_cyc; w0 = awv_cyc; d0 = done_cnt;
        do_start(32'h1000, 32'h2000, 0);
        chk("zero_n1", {done, busy}, 2'b10);
        repeat (4) @(negedge clk);
        chk("zero_no_axi", {32'(arv_cyc - a0), 32'(awv_cyc - w0)}, 64'h0);
        chk("zero_done_pulses", done_cnt - d0, 1);

        // Backpressure: read gaps plus held-off WREADY fills the 2-deep FIFO
        r_gaps = 1;
        @(negedge clk);
        clear_logs();
        src_addr = 32'h4000; dst_addr = 32'h7000; length = 20; start = 1; w_hold = 12;
        @(negedge clk);
        start = 0;
        wait_done("bp", 1000);
        r_gaps = 0;
        chk("bp_rready_stall", rstall > 0, 1);
        chk("bp_arlen", {ar_len_log[0], ar_len_log[1]}, {4'd15, 4'd3});
        check_copy("bp", 32'h4000, 20);

        // BRESP error on first of three bursts stops further bursts
        b_err_next = 1;
        do_start(32'h1000, 32'h2000, 40);
        wait_done("berr", 300);
        chk("berr_err", err, 1);
        chk("berr_nbursts", {32'(ar_addr_log.size()), 32'(aw_addr_log.size())}, {32'd1, 32'd1});
        check_copy("berr", 32'h1000, 16);

        // Next start clears err
        do_start(32'h1000, 32'h2000, 3);
        chk("clr_err_n1", {err, busy}, 2'b01);
        wait_done("clr", 100);
        chk("clr_err_end", err, 0);
        check_copy("clr", 32'h1000, 3);

        // RRESP error on the middle beat: beat still written, err set
        r_err_en = 1; r_err_addr = 32'h1004;
        do_start(32'h1000, 32'h2400, 3);
        wait_done("rerr", 100);
        r_err_en = 0;
        chk("rerr_err", err, 1);
        check_copy("rerr", 32'h1000, 3);

        // Reset mid-transfer
        do_start(32'h1000, 32'h2000, 40);
        k = 0;
        while (!WVALID && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_xfer", WVALID, 1);
        d0 = done_cnt;
        rst = 0;
        #1;
        chk("rst_outputs", {busy, done, err, ARVALID, AWVALID, RREADY, WVALID, WLAST, BREADY}, 9'b0);
        RVALID = 0; RLAST = 0; RRESP = 0; BVALID = 0; BRESP = 0;
        rq_addr.delete(); rq_last.delete(); b_pend = 0; w_hold = 0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        rst = 1;
        @(negedge clk);
        do_start(32'h3000, 32'h4000, 3);
        wait_done("recover", 100);
        check_copy("recover", 32'h3000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
